// File: rtl/div8s4_seq.sv
// Sequential signed 8-by-4 divider: restoring division on magnitudes over
// eight cycles, then one cycle of sign correction and special-case handling.
module div8s4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quot,
  output logic [3:0] rem,
  output logic       dbz,
  output logic       ovf
);

  // Handshake: a pair is taken on a rising edge with in_valid && in_ready;
  // a result is consumed on a rising edge with out_valid && out_ready.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] a_reg;
  logic [3:0] b_reg;
  logic       sign_a, sign_b;
  logic [7:0] q_sh;
  logic [3:0] b_mag;
  logic [4:0] p_rem;
  logic [2:0] cnt;

  logic       accept;
  logic [7:0] a_abs;
  logic [3:0] b_abs;
  logic [5:0] r_shift;
  logic [4:0] trial;
  logic       take;

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // |-128| wraps to 8'h80, which is exactly 128 as an unsigned magnitude.
  assign a_abs = dividend[7] ? (~dividend + 8'd1) : dividend;
  assign b_abs = divisor[3]  ? (~divisor + 4'd1)  : divisor;

  assign r_shift = {p_rem, q_sh[7]};
  assign take    = (r_shift >= {2'b00, b_mag});
  assign trial   = r_shift[4:0] - {1'b0, b_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (cnt == 3'd7) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= 8'h00;
      b_reg  <= 4'h0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      q_sh   <= 8'h00;
      b_mag  <= 4'h0;
      p_rem  <= 5'h00;
      cnt    <= 3'd0;
      quot   <= 8'h00;
      rem    <= 4'h0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg  <= dividend;
        b_reg  <= divisor;
        sign_a <= dividend[7];
        sign_b <= divisor[3];
        q_sh   <= a_abs;
        b_mag  <= b_abs;
        p_rem  <= 5'h00;
        cnt    <= 3'd0;
      end else if (state == CALC) begin
        // q_sh shifts dividend bits out at the top and quotient bits in at the bottom
        q_sh  <= {q_sh[6:0], take};
        p_rem <= take ? trial : r_shift[4:0];
        cnt   <= cnt + 3'd1;
      end else if (state == FIX) begin
        if (b_reg == 4'h0) begin
          quot <= 8'hFF;
          rem  <= a_reg[3:0];
          dbz  <= 1'b1;
          ovf  <= 1'b0;
        end else if (a_reg == 8'h80 && b_reg == 4'hF) begin
          quot <= 8'h80;
          rem  <= 4'h0;
          dbz  <= 1'b0;
          ovf  <= 1'b1;
        end else begin
          quot <= (sign_a ^ sign_b) ? -q_sh : q_sh;
          rem  <= sign_a ? -p_rem[3:0] : p_rem[3:0];
          dbz  <= 1'b0;
          ovf  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div8s4_seq.sv
// Bench for div8s4_seq: directed vectors with literal results, handshake and
// reset scenarios, then an exhaustive sweep scored against an arithmetic model.
module tb_div8s4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [3:0] rem;
  logic       dbz;
  logic       ovf;

  int checks   = 0;
  int failures = 0;
  logic [13:0] exp_q[$];

  div8s4_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {quot, rem, dbz, ovf}; truncating division via SV ints.
  function automatic logic [13:0] model(input logic [7:0] a, input logic [3:0] b);
    int ia, ib, q, r;
    ia = $signed(a);
    ib = $signed(b);
    if (ib == 0) return {8'hFF, a[3:0], 1'b1, 1'b0};
    if (ia == -128 && ib == -1) return {8'h80, 4'h0, 1'b0, 1'b1};
    q = ia / ib;
    r = ia % ib;
    return {q[7:0], r[3:0], 1'b0, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // scoreboard: every cycle a result is presented it must match the head
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%h expected=none", {quot, rem, dbz, ovf});
      end else begin
        if ({quot, rem, dbz, ovf} !== exp_q[0]) begin
          failures++;
          $display("FAIL scoreboard got=%h expected=%h", {quot, rem, dbz, ovf}, exp_q[0]);
        end
        if (in_ready) begin
          failures++;
          $display("FAIL in_ready_in_done got=1 expected=0");
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: called and returns at posedge+2
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int hold,
                       input bit noise, output logic [13:0] res);
    int guard;
    int edges;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #2;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    edges = 1;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid) break;
      if (noise) begin
        #1;
        in_valid = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("latency_edges", edges, 10);
    res = {quot, rem, dbz, ovf};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {18'd0, quot, rem, dbz, ovf}, {18'd0, res});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  logic [7:0]  vec_a   [7];
  logic [3:0]  vec_b   [7];
  logic [13:0] vec_exp [7];
  int          vec_hold[7];
  bit          vec_noise[7];

  initial begin
    logic [13:0] res;
    vec_a[0] = 8'h64; vec_b[0] = 4'h7; vec_exp[0] = {8'h0E, 4'h2, 1'b0, 1'b0}; vec_hold[0] = 0; vec_noise[0] = 0;
    vec_a[1] = 8'h9C; vec_b[1] = 4'h7; vec_exp[1] = {8'hF2, 4'hE, 1'b0, 1'b0}; vec_hold[1] = 0; vec_noise[1] = 1;
    vec_a[2] = 8'h64; vec_b[2] = 4'h9; vec_exp[2] = {8'hF2, 4'h2, 1'b0, 1'b0}; vec_hold[2] = 5; vec_noise[2] = 0;
    vec_a[3] = 8'h9C; vec_b[3] = 4'h9; vec_exp[3] = {8'h0E, 4'hE, 1'b0, 1'b0}; vec_hold[3] = 0; vec_noise[3] = 1;
    vec_a[4] = 8'h80; vec_b[4] = 4'hF; vec_exp[4] = {8'h80, 4'h0, 1'b0, 1'b1}; vec_hold[4] = 0; vec_noise[4] = 0;
    vec_a[5] = 8'h25; vec_b[5] = 4'h0; vec_exp[5] = {8'hFF, 4'h5, 1'b1, 1'b0}; vec_hold[5] = 3; vec_noise[5] = 0;
    vec_a[6] = 8'h80; vec_b[6] = 4'h8; vec_exp[6] = {8'h10, 4'h0, 1'b0, 1'b0}; vec_hold[6] = 0; vec_noise[6] = 1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'h00;
    divisor   = 4'h0;
    @(posedge clk); #1;
    chk("reset_outputs", {18'd0, quot, rem, dbz, ovf}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // model pinned against literals, then the DUT against the same literals
    for (int i = 0; i < 7; i++) begin
      chk("model_pin", {18'd0, model(vec_a[i], vec_b[i])}, {18'd0, vec_exp[i]});
      do_op(vec_a[i], vec_b[i], vec_hold[i], vec_noise[i], res);
      chk("directed", {18'd0, res}, {18'd0, vec_exp[i]});
    end

    // reset part-way through CALC: outputs clear at once, no result follows
    dividend = 8'h64;
    divisor  = 4'h7;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {18'd0, quot, rem, dbz, ovf}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    do_op(8'h64, 4'h7, 0, 0, res);
    chk("after_reset_100_7", {18'd0, res}, {18'd0, 14'({8'h0E, 4'h2, 1'b0, 1'b0})});

    // exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a[7:0], b[3:0], 0, 0, res);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
